inst_ram: RTL and testbench
===========================

INST_RAM -- requirements
Module: inst_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the instruction word width.
REQ-003 SHALL have parameter FILL_WORD, default 16'h0000, meaning the NOP encoding used for fill and for masked fetches.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port addr, input, ADDR_W, the fetch address from the PC.
REQ-007 SHALL have port dataout, output, DATA_W, the fetched instruction.
REQ-008 SHALL have port clear, input, 1, a request to refill the whole array with FILL_WORD.
REQ-009 SHALL have port ld_start, input, 1, a one-cycle pulse that starts a program load.
REQ-010 SHALL have port ld_base, input, ADDR_W, the first load address, sampled with ld_start.
REQ-011 SHALL have ports ld_valid (input, 1), ld_data (input, DATA_W) and ld_last (input, 1), forming the load beat: valid flag, instruction word, and final-word marker.
REQ-012 SHALL have port ld_ready, output, 1, the load handshake ready.
REQ-013 SHALL have port prog_ready, output, 1, high when fetches return array contents.
REQ-014 SHALL have port ld_count, output, ADDR_W+1, the number of words written by the current or last load.
REQ-015 SHALL have port ld_err, output, 1, a sticky flag set when a load runs past the top address without ld_last.

Function
REQ-016 SHALL implement FSM states CLEAR, RUN and LOAD.
REQ-017 CLEAR SHALL write FILL_WORD to mem[ptr] each cycle, with ptr running 0 to 2**ADDR_W-1, and SHALL go to RUN after writing the top address (2**ADDR_W cycles).
REQ-018 In RUN, clear=1 SHALL go to CLEAR with ptr=0; otherwise ld_start=1 SHALL go to LOAD with ptr=ld_base, ld_count=0 and ld_err=0. clear SHALL win when both are asserted.
REQ-019 ld_ready SHALL be 1 only in LOAD; a beat SHALL transfer when ld_valid and ld_ready are both high, writing mem[ptr]=ld_data, incrementing ptr and incrementing ld_count.
REQ-020 A transferred beat with ld_last=1 SHALL return the FSM to RUN the next cycle.
REQ-021 A transferred beat at ptr=2**ADDR_W-1 with ld_last=0 SHALL set ld_err and return to RUN; ptr SHALL NOT wrap to 0.
REQ-022 clear=1 in LOAD SHALL abort the load, discard any beat in that cycle, and enter CLEAR; ld_count SHALL hold its value.
REQ-023 ld_start outside RUN SHALL be ignored, and clear in CLEAR SHALL be ignored.
REQ-024 dataout SHALL be combinational: mem[addr] when the FSM is in RUN, else FILL_WORD, so a pipeline fetching during CLEAR or LOAD executes NOPs.
REQ-025 prog_ready SHALL equal (state==RUN).
REQ-026 A write and a fetch to the same address SHALL NOT occur together, because fetches are masked outside RUN.

Reset
REQ-027 On reset: state=CLEAR, ptr=0, ld_count=0, ld_err=0, ld_ready=0, prog_ready=0, dataout=FILL_WORD. The array SHALL NOT be reset directly; the CLEAR pass initialises it.
REQ-028 Reset asserted mid-LOAD or mid-CLEAR SHALL abandon the operation immediately and restart the fill from address 0 after release.

Structure
REQ-029 The opcode and register-code constants, FILL_WORD/NOP encoding, and the FSM state enum SHALL live in the shared package pcpu_pkg.
REQ-030 Storage SHALL be a sub-module inst_ram_array with one synchronous write port, one asynchronous read port, and no reset.

Verification
REQ-031 Reset release, ADDR_W=8 -> prog_ready rises exactly 256 cycles later; dataout=16'h0000 for all addr.
REQ-032 ld_start with ld_base=8'h00, then 3 beats {1100, 1200, 1300 hex} with last on beat 3 -> ld_count=3; in RUN, addr 0..2 return those words and addr 3 returns 0000.
REQ-033 Load at ld_base=8'hFE with 3 beats and no ld_last -> 2 words written, ld_err=1, ld_count=2, mem[00] unchanged.
REQ-034 ld_valid toggling 1,0,1,0 with 4 beats -> exactly 4 writes to consecutive addresses; no beat dropped or duplicated.
REQ-035 clear asserted on beat 2 of a 5-beat load -> beat 2 not written, FSM in CLEAR for 256 cycles, all words then 0000, ld_count=1.
REQ-036 Reset pulse in the middle of CLEAR -> outputs return to reset values asynchronously; the full fill restarts at 0.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared definitions for the small teaching CPU: instruction encoding
// constants, the NOP word, and the instruction-RAM controller states.
package pcpu_pkg;

    // Instruction word layout: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;
    localparam logic [2:0] REG_R2 = 3'd2;
    localparam logic [2:0] REG_R3 = 3'd3;
    localparam logic [2:0] REG_R4 = 3'd4;
    localparam logic [2:0] REG_R5 = 3'd5;
    localparam logic [2:0] REG_R6 = 3'd6;
    localparam logic [2:0] REG_R7 = 3'd7;

    // An all-zero word decodes as OP_NOP, so a blank array executes harmlessly
    localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

    // Controller modes of the instruction RAM
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } ramState_t;

    // Assemble one instruction word from its fields
    function automatic logic [15:0] mkInstr(input logic [3:0] opcode,
                                            input logic [2:0] rd,
                                            input logic [2:0] rs,
                                            input logic [5:0] imm);
        return {opcode, rd, rs, imm};
    endfunction

endpackage

// File: rtl/inst_ram_array.sv
// Instruction storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the controller's fill pass
// initialises them.
module inst_ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Write port: one word per rising edge when enabled
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_ram.sv
// Instruction RAM with a fill/clear engine and a streaming program loader.
// Fetches only see the array in RUN; during CLEAR and LOAD they return the
// fill word so the pipeline executes NOPs and never reads a word being written.
module inst_ram
    import pcpu_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataout,
    input  logic              clear,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              prog_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
);

    localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

    ramState_t         r_state;
    ramState_t         w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_nextPtr;
    logic [ADDR_W:0]   r_ldCount;
    logic [ADDR_W:0]   w_nextCount;
    logic              r_ldErr;
    logic              w_nextErr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    inst_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_clock (clock),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (w_wdata),
        .i_raddr (addr),
        .o_rdata (w_rdata)
    );

    // State, pointer, beat counter and error flag; reset abandons any fill or load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_ptr     <= '0;
            r_ldCount <= '0;
            r_ldErr   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ptr     <= w_nextPtr;
            r_ldCount <= w_nextCount;
            r_ldErr   <= w_nextErr;
        end
    end

    // Next-state and write-port control; clear always wins over loading
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextCount = r_ldCount;
        w_nextErr   = r_ldErr;
        w_we        = 1'b0;
        w_wdata     = FILL_WORD;

        case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_ptr == TOP_ADDR) begin
                    w_nextState = RUN;
                end else begin
                    w_nextPtr = r_ptr + PTR_ONE;
                end
            end

            RUN: begin
                if (clear) begin
                    w_nextState = CLEAR;
                    w_nextPtr   = '0;
                end else if (ld_start) begin
                    w_nextState = LOAD;
                    w_nextPtr   = ld_base;
                    w_nextCount = '0;
                    w_nextErr   = 1'b0;
                end
            end

            LOAD: begin
                if (clear) begin
                    w_nextState = CLEAR;
                    w_nextPtr   = '0;
                end else if (ld_valid) begin
                    w_we        = 1'b1;
                    w_wdata     = ld_data;
                    w_nextCount = r_ldCount + COUNT_ONE;
                    if (ld_last) begin
                        w_nextState = RUN;
                        if (r_ptr != TOP_ADDR) begin
                            w_nextPtr = r_ptr + PTR_ONE;
                        end
                    end else if (r_ptr == TOP_ADDR) begin
                        w_nextState = RUN;
                        w_nextErr   = 1'b1;
                    end else begin
                        w_nextPtr = r_ptr + PTR_ONE;
                    end
                end
            end

            default: begin
                w_nextState = CLEAR;
                w_nextPtr   = '0;
            end
        endcase
    end

    assign ld_ready   = (r_state == LOAD);
    assign prog_ready = (r_state == RUN);
    assign dataout    = prog_ready ? w_rdata : FILL_WORD;
    assign ld_count   = r_ldCount;
    assign ld_err     = r_ldErr;

endmodule

// File: tb/tb_inst_ram.sv
// Scoreboard bench for inst_ram: stimulus pushes expected values into a
// queue and strobes a probe; a monitor pops and compares on the falling edge.
module tb_inst_ram;

    localparam int SEL_DATA  = 0;
    localparam int SEL_COUNT = 1;
    localparam int SEL_ERR   = 2;
    localparam int SEL_PROG  = 3;
    localparam int SEL_LDRDY = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sbItem_t;

    logic        clock;
    logic        reset;
    logic [7:0]  addr;
    logic [15:0] dataout;
    logic        clear;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        prog_ready;
    logic [8:0]  ld_count;
    logic        ld_err;

    logic        probe;
    sbItem_t     sbQ[$];
    sbItem_t     monItem;
    logic [31:0] monAct;
    int          errors;
    int          checks;

    inst_ram #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .FILL_WORD (16'h0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .dataout    (dataout),
        .clear      (clear),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .prog_ready (prog_ready),
        .ld_count   (ld_count),
        .ld_err     (ld_err)
    );

    // Free-running 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single place where every comparison is counted and reported
    function automatic void compare(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: whenever a probe is presented, pop the expected item and
    // compare against the selected DUT output, away from the rising edge
    always @(negedge clock) begin
        if (probe) begin
            if (sbQ.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL scoreboard_underflow: got empty expected item");
            end else begin
                monItem = sbQ.pop_front();
                case (monItem.sel)
                    SEL_DATA:  monAct = {16'h0, dataout};
                    SEL_COUNT: monAct = {23'h0, ld_count};
                    SEL_ERR:   monAct = {31'h0, ld_err};
                    SEL_PROG:  monAct = {31'h0, prog_ready};
                    default:   monAct = {31'h0, ld_ready};
                endcase
                compare(monItem.name, monAct, monItem.exp);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue an expectation and present it to the monitor for one cycle
    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        sbItem_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sbQ.push_back(it);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic checkFetch(input string name, input logic [7:0] a, input logic [15:0] exp);
        addr = a;
        checkOutput(name, SEL_DATA, {16'h0, exp});
    endtask

    // One cycle of load-port activity, then the port returns to idle
    task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                 input logic last, input logic clr);
        ld_valid = valid;
        ld_data  = data;
        ld_last  = last;
        clear    = clr;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic startLoad(input logic [7:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
    endtask

    // Count cycles until prog_ready, optionally holding clear for the first few
    task automatic waitReady(input string name, input int holdClear, input int expCycles);
        int n;
        n = 0;
        while (!prog_ready && n < 1000) begin
            clear = (n < holdClear);
            tick();
            n++;
        end
        clear = 1'b0;
        compare(name, n, expCycles);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        probe    = 1'b0;
        reset    = 1'b1;
        addr     = 8'h00;
        clear    = 1'b0;
        ld_start = 1'b0;
        ld_base  = 8'h00;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        ld_last  = 1'b0;

        // Reset values
        tick();
        checkOutput("rst_prog_ready", SEL_PROG, 0);
        checkOutput("rst_ld_ready", SEL_LDRDY, 0);
        checkOutput("rst_ld_count", SEL_COUNT, 0);
        checkOutput("rst_ld_err", SEL_ERR, 0);
        checkFetch("rst_dataout", 8'h37, 16'h0000);

        // Initial fill takes one cycle per word
        reset = 1'b0;
        waitReady("fill_cycles", 0, 256);
        for (int a = 0; a < 256; a += 17) begin
            checkFetch($sformatf("fill_word_%0h", a), 8'(a), 16'h0000);
        end
        checkFetch("fill_word_ff", 8'hFF, 16'h0000);

        // Three-word load at base 0
        startLoad(8'h00);
        checkOutput("load0_ld_ready", SEL_LDRDY, 1);
        applyStimulus(1'b1, 16'h1100, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1200, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1300, 1'b1, 1'b0);
        checkOutput("load0_prog_ready", SEL_PROG, 1);
        checkOutput("load0_count", SEL_COUNT, 3);
        checkOutput("load0_err", SEL_ERR, 0);
        checkFetch("load0_m00", 8'h00, 16'h1100);
        checkFetch("load0_m01", 8'h01, 16'h1200);
        checkFetch("load0_m02", 8'h02, 16'h1300);
        checkFetch("load0_m03", 8'h03, 16'h0000);

        // Load running off the top without a last marker
        startLoad(8'hFE);
        applyStimulus(1'b1, 16'hA0FE, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hA0FF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hA100, 1'b0, 1'b0);
        checkOutput("ovf_err", SEL_ERR, 1);
        checkOutput("ovf_count", SEL_COUNT, 2);
        checkOutput("ovf_prog_ready", SEL_PROG, 1);
        checkFetch("ovf_mfe", 8'hFE, 16'hA0FE);
        checkFetch("ovf_mff", 8'hFF, 16'hA0FF);
        checkFetch("ovf_m00", 8'h00, 16'h1100);
        checkFetch("ovf_m01", 8'h01, 16'h1200);

        // Gapped beats at base 0x10; ld_start during LOAD must be ignored
        startLoad(8'h10);
        checkFetch("load_masked_fetch", 8'h00, 16'h0000);
        checkOutput("load_prog_low", SEL_PROG, 0);
        applyStimulus(1'b1, 16'hD001, 1'b0, 1'b0);
        ld_start = 1'b1;
        ld_base  = 8'h80;
        applyStimulus(1'b0, 16'hEEEE, 1'b0, 1'b0);
        ld_start = 1'b0;
        applyStimulus(1'b1, 16'hD002, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hEEEE, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hD003, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hEEEE, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hD004, 1'b1, 1'b0);
        checkOutput("gap_count", SEL_COUNT, 4);
        checkOutput("gap_err", SEL_ERR, 0);
        checkFetch("gap_m0f", 8'h0F, 16'h0000);
        checkFetch("gap_m10", 8'h10, 16'hD001);
        checkFetch("gap_m11", 8'h11, 16'hD002);
        checkFetch("gap_m12", 8'h12, 16'hD003);
        checkFetch("gap_m13", 8'h13, 16'hD004);
        checkFetch("gap_m14", 8'h14, 16'h0000);
        checkFetch("gap_m80", 8'h80, 16'h0000);

        // Clear on beat 2 aborts the load; clear held in CLEAR is ignored
        startLoad(8'h20);
        applyStimulus(1'b1, 16'hB001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hB002, 1'b0, 1'b1);
        waitReady("abort_clear_cycles", 3, 256);
        checkOutput("abort_count", SEL_COUNT, 1);
        checkFetch("abort_m20", 8'h20, 16'h0000);
        checkFetch("abort_m21", 8'h21, 16'h0000);
        checkFetch("abort_m00", 8'h00, 16'h0000);
        checkFetch("abort_m10", 8'h10, 16'h0000);
        checkFetch("abort_mfe", 8'hFE, 16'h0000);

        // Single word at the top address sets the error flag
        startLoad(8'hFF);
        applyStimulus(1'b1, 16'hC0FF, 1'b0, 1'b0);
        checkOutput("top_err", SEL_ERR, 1);
        checkOutput("top_count", SEL_COUNT, 1);
        checkFetch("top_mff", 8'hFF, 16'hC0FF);

        // clear and ld_start together: clear wins
        clear    = 1'b1;
        ld_start = 1'b1;
        ld_base  = 8'h40;
        tick();
        clear    = 1'b0;
        ld_start = 1'b0;
        checkOutput("clr_wins_ld_ready", SEL_LDRDY, 0);
        checkOutput("clr_wins_prog", SEL_PROG, 0);
        checkFetch("clr_masked_fetch", 8'hFF, 16'h0000);

        // Asynchronous reset in the middle of CLEAR
        reset = 1'b1;
        checkOutput("async_rst_count", SEL_COUNT, 0);
        checkOutput("async_rst_err", SEL_ERR, 0);
        reset = 1'b0;
        waitReady("refill_cycles", 0, 256);
        checkFetch("refill_mff", 8'hFF, 16'h0000);
        checkFetch("refill_m00", 8'h00, 16'h0000);

        if (sbQ.size() != 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", sbQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
